if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage. Owns the program counter and drives the read-only IF port (port A) of the SPM.
//  Captures each fetched word with its PC into the IF/ID pipeline register for the decode stage.
//  Handles pipeline stall, exception/interrupt flush and taken-branch redirect.
//  Flags fetches outside the SPM window as a fault.
// PARAMETERS
//  ADDR_W        30     PC width in words (byte address = {pc,2'b00})
//  SPM_ADDR_W    12     SPM word-address width; pc[ADDR_W-1:SPM_ADDR_W] must be 0 for a legal fetch
//  DATA_W        32     instruction width
//  RESET_VECTOR  0      word address of the first fetch after reset
//  NOP_INSN      32'h0  word inserted on a bubble, flush or fault
// PORTS
//  clk             in   1           single clock, rising edge
//  reset_n         in   1           asynchronous, active-low reset
//  stall           in   1           hold PC and IF/ID register
//  flush           in   1           exception/interrupt redirect
//  new_pc          in   ADDR_W      flush target
//  br_taken        in   1           taken branch from ID
//  br_addr         in   ADDR_W      branch target
//  if_spm_as       out  1           SPM port-A access strobe, constant 1
//  if_spm_rw       out  1           constant 0 (read); this port never writes
//  if_spm_addr     out  SPM_ADDR_W  SPM port-A word address
//  if_spm_wr_data  out  DATA_W      constant 0
//  if_spm_rd_data  in   DATA_W      SPM read data, 1-cycle synchronous latency
//  if_pc           out  ADDR_W      PC of if_insn
//  if_insn         out  DATA_W      fetched instruction
//  if_en           out  1           IF/ID entry valid
//  if_fault        out  1           if_insn came from an address outside the SPM
// BEHAVIOUR
//  Registers:
//   - pc: address whose data is on if_spm_rd_data this cycle.
//   - primed: 0 until the first edge after reset.
//   - IF/ID: if_pc, if_insn, if_en, if_fault.
//  Reset (async, reset_n=0):
//   - pc=RESET_VECTOR, primed=0, if_pc=RESET_VECTOR, if_insn=NOP_INSN, if_en=0, if_fault=0.
//  next_pc priority, highest first:
//   - flush: new_pc.
//   - stall: pc.
//   - !primed: pc.
//   - br_taken: br_addr.
//   - otherwise pc+1, which wraps modulo 2^ADDR_W.
//  if_spm_addr = next_pc[SPM_ADDR_W-1:0] (combinational), so SPM data always belongs to the registered pc.
//  Each rising edge, in priority order:
//   - flush: pc<=new_pc; if_en<=0, if_insn<=NOP_INSN, if_fault<=0. Flush overrides stall and br_taken.
//   - stall: all registers hold; br_taken is ignored (ID re-presents it).
//   - !primed: primed<=1; IF/ID keeps its reset values. This gives one bubble after reset.
//   - br_taken: pc<=br_addr; IF/ID <= bubble (if_en=0, if_insn=NOP_INSN). No delay slot: the word at pc is squashed.
//   - normal:
//       pc<=pc+1; if_pc<=pc; if_en<=1.
//       Legal pc: if_insn<=if_spm_rd_data, if_fault<=0.
//       Out-of-window pc (upper bits !=0): if_insn<=NOP_INSN, if_fault<=1.
//  Latency: an instruction appears on IF/ID two edges after its address is driven on if_spm_addr.
//  Steady state (no stall/branch/flush) delivers one instruction per cycle.
//  Reset asserted mid-operation clears everything immediately; fetch restarts at RESET_VECTOR with one bubble.
//  flush held across several cycles: each edge reloads pc from new_pc; if_en stays 0.
// STRUCTURE
//  Shared package cpu_pkg:
//   - WORD / WORD_ADDR widths, SPM_ADDR_W, NOP_INSN, RESET_VECTOR.
//  Sub-module if_reg: the IF/ID pipeline register.
//   - Async reset; stall/flush/bubble controls; the fault flag.
//  if_stage holds the PC, primed flag, next-PC mux and SPM port drive.
// TESTING
//  1. Reset release, SPM[0..3]=A0..A3 -> if_spm_addr 0,0,1,2,...;
//     if_en low for 1 cycle, then (if_pc,if_insn)=(0,A0),(1,A1),(2,A2).
//  2. stall high for 3 cycles mid-stream at pc=5 -> if_pc/if_insn frozen at (4,A4);
//     if_spm_addr stays 5; resume yields (5,A5) with no loss or duplication.
//  3. br_taken with br_addr=0x20 while pc=7 -> next IF/ID is a bubble (if_en=0);
//     next valid entry is (0x20, SPM[0x20]); word 7 never issued.
//  4. flush (new_pc=0x10) and br_taken(0x30) and stall in the same cycle -> flush wins;
//     bubble, then (0x10, SPM[0x10]).
//  5. Branch to pc=0x1000 (bit 12 set) -> if_en=1, if_fault=1, if_insn=NOP_INSN, if_pc=0x1000;
//     pc advances to 0x1001.
//  6. reset_n pulsed low mid-stream for <1 cycle -> outputs clear asynchronously;
//     fetch restarts at RESET_VECTOR with one bubble.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: word/address widths, SPM window size, the NOP
// encoding used for bubbles, and the reset fetch vector.
package cpu_pkg;

    localparam int WORD_W      = 32;  // instruction / data word width
    localparam int WORD_ADDR_W = 30;  // word address width (byte addr = {a,2'b00})
    localparam int SPM_ADDR_W  = 12;  // SPM word-address width

    localparam logic [WORD_W-1:0]      NOP_INSN     = 32'h0000_0000;
    localparam logic [WORD_ADDR_W-1:0] RESET_VECTOR = 30'h0;

endpackage : cpu_pkg

// File: rtl/if_stage_if.sv
// SPM port-A bundle between the fetch stage (master) and the scratch-pad
// memory (slave).
//   if_spm_as      : access strobe
//   if_spm_rw      : 0 = read, 1 = write
//   if_spm_addr    : word address
//   if_spm_wr_data : write data
//   if_spm_rd_data : read data, returned one clock after the address
// Handshake: there is no valid/ready pair; the master presents an address
// every cycle with if_spm_as=1 and the slave answers on the next cycle
// unconditionally, so every address issued is accepted.
interface if_stage_if
    import cpu_pkg::*;
#(
    parameter int SPM_ADDR_W = cpu_pkg::SPM_ADDR_W,
    parameter int DATA_W     = cpu_pkg::WORD_W
);
    logic                  if_spm_as;
    logic                  if_spm_rw;
    logic [SPM_ADDR_W-1:0] if_spm_addr;
    logic [DATA_W-1:0]     if_spm_wr_data;
    logic [DATA_W-1:0]     if_spm_rd_data;

    modport master (
        output if_spm_as, if_spm_rw, if_spm_addr, if_spm_wr_data,
        input  if_spm_rd_data
    );

    modport slave (
        input  if_spm_as, if_spm_rw, if_spm_addr, if_spm_wr_data,
        output if_spm_rd_data
    );
endinterface : if_stage_if

// File: rtl/if_stage_reg.sv
// IF/ID pipeline register.
//   clk, reset_n : clock, asynchronous active-low reset
//   stall        : hold every field
//   flush        : clear to an invalid NOP entry (beats stall)
//   hold         : hold every field (pre-priming cycle after reset)
//   bubble       : load an invalid NOP entry (taken branch squash)
//   pc_in        : PC of the word on insn_in
//   insn_in      : fetched word
//   fault_in     : pc_in lies outside the SPM window
//   if_pc, if_insn, if_en, if_fault : registered IF/ID entry
module if_reg
    import cpu_pkg::*;
#(
    parameter int                 ADDR_W       = cpu_pkg::WORD_ADDR_W,
    parameter int                 DATA_W       = cpu_pkg::WORD_W,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = cpu_pkg::RESET_VECTOR,
    parameter logic [DATA_W-1:0]  NOP_INSN     = cpu_pkg::NOP_INSN
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              hold,
    input  logic              bubble,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [DATA_W-1:0] insn_in,
    input  logic              fault_in,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_insn,
    output logic              if_en,
    output logic              if_fault
);
    logic [ADDR_W-1:0] pc_d,    pc_q;
    logic [DATA_W-1:0] insn_d,  insn_q;
    logic              en_d,    en_q;
    logic              fault_d, fault_q;

    always_comb begin
        pc_d    = pc_q;
        insn_d  = insn_q;
        en_d    = en_q;
        fault_d = fault_q;
        if (flush || (!stall && !hold && bubble)) begin
            // if_pc is left alone: it is meaningless while if_en=0.
            insn_d  = NOP_INSN;
            en_d    = 1'b0;
            fault_d = 1'b0;
        end else if (!stall && !hold) begin
            pc_d    = pc_in;
            // A fault entry carries NOP so decode never sees aliased SPM data.
            insn_d  = fault_in ? NOP_INSN : insn_in;
            en_d    = 1'b1;
            fault_d = fault_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_VECTOR;
            insn_q  <= NOP_INSN;
            en_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            insn_q  <= insn_d;
            en_q    <= en_d;
            fault_q <= fault_d;
        end
    end

    assign if_pc    = pc_q;
    assign if_insn  = insn_q;
    assign if_en    = en_q;
    assign if_fault = fault_q;
endmodule : if_reg

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives SPM port A and fills the
// IF/ID register.
//   clk, reset_n       : clock, asynchronous active-low reset
//   stall              : hold PC and IF/ID
//   flush, new_pc      : exception/interrupt redirect (highest priority)
//   br_taken, br_addr  : taken branch from decode
//   spm                : SPM port A (master side)
//   if_pc, if_insn     : IF/ID entry
//   if_en              : IF/ID entry valid
//   if_fault           : entry was fetched from outside the SPM window
module if_stage
    import cpu_pkg::*;
#(
    parameter int                 ADDR_W       = cpu_pkg::WORD_ADDR_W,
    parameter int                 SPM_ADDR_W   = cpu_pkg::SPM_ADDR_W,
    parameter int                 DATA_W       = cpu_pkg::WORD_W,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = cpu_pkg::RESET_VECTOR,
    parameter logic [DATA_W-1:0]  NOP_INSN     = cpu_pkg::NOP_INSN
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    if_stage_if.master        spm,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_insn,
    output logic              if_en,
    output logic              if_fault
);
    // pc_q is the address whose data is on if_spm_rd_data this cycle.
    logic [ADDR_W-1:0] pc_d, pc_q;
    logic              primed_d, primed_q;
    logic              pc_legal;

    always_comb begin
        pc_d     = pc_q;
        primed_d = primed_q;
        if (flush) begin
            pc_d = new_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (!primed_q) begin
            // First edge after reset: SPM has not yet returned data for pc.
            primed_d = 1'b1;
        end else if (br_taken) begin
            pc_d = br_addr;
        end else begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q     <= RESET_VECTOR;
            primed_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            primed_q <= primed_d;
        end
    end

    // Address the SPM with next_pc so its data lines up with pc_q next cycle.
    assign spm.if_spm_as      = 1'b1;
    assign spm.if_spm_rw      = 1'b0;
    assign spm.if_spm_addr    = pc_d[SPM_ADDR_W-1:0];
    assign spm.if_spm_wr_data = '0;

    assign pc_legal = ((pc_q >> SPM_ADDR_W) == '0);

    if_reg #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .RESET_VECTOR (RESET_VECTOR),
        .NOP_INSN     (NOP_INSN)
    ) u_if_reg (
        .clk      (clk),
        .reset_n  (reset_n),
        .stall    (stall),
        .flush    (flush),
        .hold     (!primed_q),
        .bubble   (br_taken),
        .pc_in    (pc_q),
        .insn_in  (spm.if_spm_rd_data),
        .fault_in (!pc_legal),
        .if_pc    (if_pc),
        .if_insn  (if_insn),
        .if_en    (if_en),
        .if_fault (if_fault)
    );
endmodule : if_stage

// File: tb/tb_if_stage.sv
// Directed bench for if_stage. SPM word i holds 32'hC0DE_0000 | i, so the
// expected instruction for a given PC is written out by hand in each test.
module tb_if_stage;
    import cpu_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        flush;
    logic [29:0] new_pc;
    logic        br_taken;
    logic [29:0] br_addr;
    logic [29:0] if_pc;
    logic [31:0] if_insn;
    logic        if_en;
    logic        if_fault;

    int checks;
    int failures;

    logic [31:0] mem [0:4095];

    if_stage_if spm_if ();

    if_stage dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .stall    (stall),
        .flush    (flush),
        .new_pc   (new_pc),
        .br_taken (br_taken),
        .br_addr  (br_addr),
        .spm      (spm_if.master),
        .if_pc    (if_pc),
        .if_insn  (if_insn),
        .if_en    (if_en),
        .if_fault (if_fault)
    );

    // clock / SPM model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) spm_if.if_spm_rd_data <= mem[spm_if.if_spm_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks one IF/ID entry against a valid, non-fault expectation.
    // (Inline per scenario; each test does its own comparisons.)

    task automatic test_reset();
        reset_n = 1'b0; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
        new_pc = '0; br_addr = '0;
        repeat (2) tick();
        checks++; if (if_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%0b exp=0", if_en); end
        checks++; if (if_pc !== 30'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", if_pc); end
        checks++; if (if_insn !== 32'h0) begin failures++; $display("FAIL reset_insn got=%h exp=0", if_insn); end
        checks++; if (if_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%0b exp=0", if_fault); end
        checks++; if (spm_if.if_spm_addr !== 12'h000) begin failures++; $display("FAIL reset_addr got=%h exp=000", spm_if.if_spm_addr); end
        checks++; if (spm_if.if_spm_as !== 1'b1 || spm_if.if_spm_rw !== 1'b0 || spm_if.if_spm_wr_data !== 32'h0) begin
            failures++; $display("FAIL reset_port as=%0b rw=%0b wd=%h exp as=1 rw=0 wd=0", spm_if.if_spm_as, spm_if.if_spm_rw, spm_if.if_spm_wr_data);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_fetch();
        checks++; if (spm_if.if_spm_addr !== 12'h000) begin failures++; $display("FAIL fetch_addr0 got=%h exp=000", spm_if.if_spm_addr); end
        tick();
        checks++; if (if_en !== 1'b0) begin failures++; $display("FAIL fetch_bubble en got=%0b exp=0", if_en); end
        checks++; if (spm_if.if_spm_addr !== 12'h001) begin failures++; $display("FAIL fetch_addr1 got=%h exp=001", spm_if.if_spm_addr); end
        tick();
        checks++; if (if_en !== 1'b1 || if_pc !== 30'h0 || if_insn !== 32'hC0DE_0000) begin
            failures++; $display("FAIL fetch_w0 en=%0b pc=%h insn=%h exp 1/0/c0de0000", if_en, if_pc, if_insn); end
        checks++; if (spm_if.if_spm_addr !== 12'h002) begin failures++; $display("FAIL fetch_addr2 got=%h exp=002", spm_if.if_spm_addr); end
        tick();
        checks++; if (if_en !== 1'b1 || if_pc !== 30'h1 || if_insn !== 32'hC0DE_0001) begin
            failures++; $display("FAIL fetch_w1 en=%0b pc=%h insn=%h exp 1/1/c0de0001", if_en, if_pc, if_insn); end
        tick();
        checks++; if (if_en !== 1'b1 || if_pc !== 30'h2 || if_insn !== 32'hC0DE_0002) begin
            failures++; $display("FAIL fetch_w2 en=%0b pc=%h insn=%h exp 1/2/c0de0002", if_en, if_pc, if_insn); end
        tick();
        tick();
        checks++; if (if_en !== 1'b1 || if_pc !== 30'h4 || if_insn !== 32'hC0DE_0004 || if_fault !== 1'b0) begin
            failures++; $display("FAIL fetch_w4 en=%0b pc=%h insn=%h flt=%0b exp 1/4/c0de0004/0", if_en, if_pc, if_insn, if_fault); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        #1;
        checks++; if (spm_if.if_spm_addr !== 12'h005) begin failures++; $display("FAIL stall_addr got=%h exp=005", spm_if.if_spm_addr); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (if_en !== 1'b1 || if_pc !== 30'h4 || if_insn !== 32'hC0DE_0004 || spm_if.if_spm_addr !== 12'h005) begin
                failures++; $display("FAIL stall_hold%0d en=%0b pc=%h insn=%h addr=%h exp 1/4/c0de0004/005", i, if_en, if_pc, if_insn, spm_if.if_spm_addr); end
        end
        stall = 1'b0;
        tick();
        checks++; if (if_en !== 1'b1 || if_pc !== 30'h5 || if_insn !== 32'hC0DE_0005) begin
            failures++; $display("FAIL stall_resume5 en=%0b pc=%h insn=%h exp 1/5/c0de0005", if_en, if_pc, if_insn); end
        tick();
        checks++; if (if_en !== 1'b1 || if_pc !== 30'h6 || if_insn !== 32'hC0DE_0006) begin
            failures++; $display("FAIL stall_resume6 en=%0b pc=%h insn=%h exp 1/6/c0de0006", if_en, if_pc, if_insn); end
    endtask

    task automatic test_branch();
        br_taken = 1'b1; br_addr = 30'h20;
        #1;
        checks++; if (spm_if.if_spm_addr !== 12'h020) begin failures++; $display("FAIL br_addr got=%h exp=020", spm_if.if_spm_addr); end
        tick();
        checks++; if (if_en !== 1'b0 || if_insn !== 32'h0) begin failures++; $display("FAIL br_bubble en=%0b insn=%h exp 0/0", if_en, if_insn); end
        br_taken = 1'b0;
        #1;
        checks++; if (spm_if.if_spm_addr !== 12'h021) begin failures++; $display("FAIL br_addr_next got=%h exp=021", spm_if.if_spm_addr); end
        tick();
        checks++; if (if_en !== 1'b1 || if_pc !== 30'h20 || if_insn !== 32'hC0DE_0020) begin
            failures++; $display("FAIL br_target en=%0b pc=%h insn=%h exp 1/20/c0de0020", if_en, if_pc, if_insn); end
    endtask

    task automatic test_flush();
        flush = 1'b1; new_pc = 30'h10; br_taken = 1'b1; br_addr = 30'h30; stall = 1'b1;
        #1;
        checks++; if (spm_if.if_spm_addr !== 12'h010) begin failures++; $display("FAIL flush_addr got=%h exp=010", spm_if.if_spm_addr); end
        tick();
        checks++; if (if_en !== 1'b0 || if_insn !== 32'h0 || if_fault !== 1'b0) begin
            failures++; $display("FAIL flush_bubble1 en=%0b insn=%h flt=%0b exp 0/0/0", if_en, if_insn, if_fault); end
        br_taken = 1'b0; stall = 1'b0;
        tick();
        checks++; if (if_en !== 1'b0) begin failures++; $display("FAIL flush_bubble2 en=%0b exp 0", if_en); end
        flush = 1'b0;
        tick();
        checks++; if (if_en !== 1'b1 || if_pc !== 30'h10 || if_insn !== 32'hC0DE_0010) begin
            failures++; $display("FAIL flush_target en=%0b pc=%h insn=%h exp 1/10/c0de0010", if_en, if_pc, if_insn); end
        tick();
        checks++; if (if_en !== 1'b1 || if_pc !== 30'h11 || if_insn !== 32'hC0DE_0011) begin
            failures++; $display("FAIL flush_next en=%0b pc=%h insn=%h exp 1/11/c0de0011", if_en, if_pc, if_insn); end
    endtask

    task automatic test_fault();
        br_taken = 1'b1; br_addr = 30'h1000;
        #1;
        checks++; if (spm_if.if_spm_addr !== 12'h000) begin failures++; $display("FAIL fault_addr got=%h exp=000", spm_if.if_spm_addr); end
        tick();
        br_taken = 1'b0;
        tick();
        checks++; if (if_en !== 1'b1 || if_fault !== 1'b1 || if_insn !== 32'h0 || if_pc !== 30'h1000) begin
            failures++; $display("FAIL fault_entry en=%0b flt=%0b insn=%h pc=%h exp 1/1/0/1000", if_en, if_fault, if_insn, if_pc); end
        checks++; if (spm_if.if_spm_addr !== 12'h002) begin failures++; $display("FAIL fault_addr_adv got=%h exp=002", spm_if.if_spm_addr); end
        tick();
        checks++; if (if_en !== 1'b1 || if_fault !== 1'b1 || if_pc !== 30'h1001 || if_insn !== 32'h0) begin
            failures++; $display("FAIL fault_next en=%0b flt=%0b pc=%h insn=%h exp 1/1/1001/0", if_en, if_fault, if_pc, if_insn); end
        br_taken = 1'b1; br_addr = 30'h8;
        tick();
        checks++; if (if_en !== 1'b0 || if_fault !== 1'b0) begin failures++; $display("FAIL fault_clear en=%0b flt=%0b exp 0/0", if_en, if_fault); end
        br_taken = 1'b0;
        tick();
        checks++; if (if_en !== 1'b1 || if_fault !== 1'b0 || if_pc !== 30'h8 || if_insn !== 32'hC0DE_0008) begin
            failures++; $display("FAIL fault_legal en=%0b flt=%0b pc=%h insn=%h exp 1/0/8/c0de0008", if_en, if_fault, if_pc, if_insn); end
    endtask

    task automatic test_async_reset();
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (if_en !== 1'b0 || if_pc !== 30'h0 || if_insn !== 32'h0 || if_fault !== 1'b0) begin
            failures++; $display("FAIL areset_clear en=%0b pc=%h insn=%h flt=%0b exp 0/0/0/0", if_en, if_pc, if_insn, if_fault); end
        checks++; if (spm_if.if_spm_addr !== 12'h000) begin failures++; $display("FAIL areset_addr got=%h exp=000", spm_if.if_spm_addr); end
        #1;
        reset_n = 1'b1;
        tick();
        checks++; if (if_en !== 1'b0 || spm_if.if_spm_addr !== 12'h001) begin
            failures++; $display("FAIL areset_bubble en=%0b addr=%h exp 0/001", if_en, spm_if.if_spm_addr); end
        tick();
        checks++; if (if_en !== 1'b1 || if_pc !== 30'h0 || if_insn !== 32'hC0DE_0000) begin
            failures++; $display("FAIL areset_w0 en=%0b pc=%h insn=%h exp 1/0/c0de0000", if_en, if_pc, if_insn); end
        tick();
        checks++; if (if_en !== 1'b1 || if_pc !== 30'h1 || if_insn !== 32'hC0DE_0001) begin
            failures++; $display("FAIL areset_w1 en=%0b pc=%h insn=%h exp 1/1/c0de0001", if_en, if_pc, if_insn); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        test_reset();
        test_fetch();
        test_stall();
        test_branch();
        test_flush();
        test_fault();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule : tb_if_stage
